// File: rtl/rob_multi_issue.sv
// rob_multi_issue: circular multi-lane reorder buffer with in-order multi-retire and mispredict redirect.
// Optional ROB_PERF_CNT_EN adds saturating Perf_Retired / Perf_Redirects counters.
module rob_multi_issue #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned DISP_LANES = 2,
    parameter int unsigned RET_LANES  = 2,
    parameter int unsigned CPL_PORTS  = 3,
    parameter int unsigned RRF_SIZE   = 7,
    parameter int unsigned R_CZ_SIZE  = 8,
    parameter int unsigned SB_SIZE    = 5,
    parameter int unsigned ENT_W      = 3 + RRF_SIZE + 16 + 2 + 2*R_CZ_SIZE + 1 + SB_SIZE
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          Flush,
    input  logic [DISP_LANES-1:0]         Disp_V,
    input  logic [DISP_LANES*ENT_W-1:0]   Disp_Data,
    output logic                          Disp_Ready,
    output logic [DISP_LANES*IDX_W-1:0]   Disp_Idx,
    input  logic [CPL_PORTS-1:0]          Cpl_V,
    input  logic [CPL_PORTS*IDX_W-1:0]    Cpl_Idx,
    input  logic [CPL_PORTS-1:0]          Cpl_Mispred,
    input  logic [CPL_PORTS*16-1:0]       Cpl_PC,
    output logic [RET_LANES-1:0]          Ret_V,
    output logic [RET_LANES*3-1:0]        Ret_ARF,
    output logic [RET_LANES*RRF_SIZE-1:0] Ret_RRF,
    output logic [RET_LANES-1:0]          Ret_C_V,
    output logic [RET_LANES-1:0]          Ret_Z_V,
    output logic [RET_LANES*R_CZ_SIZE-1:0] Ret_C_Addr,
    output logic [RET_LANES*R_CZ_SIZE-1:0] Ret_Z_Addr,
    output logic [RET_LANES-1:0]          Ret_SB_V,
    output logic [RET_LANES*SB_SIZE-1:0]  Ret_SB_Addr,
    output logic [RET_LANES*16-1:0]       Ret_PC,
    output logic                          Redirect_V,
    output logic [15:0]                   Redirect_PC,
    output logic [IDX_W:0]                Count,
    output logic                          Empty
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                   Perf_Retired,
    output logic [15:0]                   Perf_Redirects
`endif
);
    localparam int unsigned OFF_SBV = SB_SIZE;
    localparam int unsigned OFF_ZA  = OFF_SBV + 1;
    localparam int unsigned OFF_ZV  = OFF_ZA + R_CZ_SIZE;
    localparam int unsigned OFF_CA  = OFF_ZV + 1;
    localparam int unsigned OFF_CV  = OFF_CA + R_CZ_SIZE;
    localparam int unsigned OFF_PC  = OFF_CV + 1;
    localparam int unsigned OFF_RRF = OFF_PC + 16;
    localparam int unsigned OFF_ARF = OFF_RRF + RRF_SIZE;

    logic [IDX_W:0]       r_head, r_tail;
    logic [DEPTH-1:0]     r_done, r_mis;
    logic [ENT_W-1:0]     r_pay [DEPTH];
    logic [15:0]          r_tgt [DEPTH];

    logic [IDX_W:0]       w_count, w_free, w_nret, w_ndisp;
    logic [IDX_W-1:0]     w_ridx [RET_LANES];
    logic [ENT_W-1:0]     w_gpay [RET_LANES];
    logic [IDX_W-1:0]     w_didx [DISP_LANES];
    logic [IDX_W-1:0]     w_cidx [CPL_PORTS];
    logic [CPL_PORTS-1:0] w_cocc;
    logic [RET_LANES-1:0] w_ret;
    logic                 w_mis, w_disp;
    logic [15:0]          w_rpc;
    logic [DISP_LANES-1:0] w_disp_inc;

    assign w_count    = r_tail - r_head;
    assign w_free     = (IDX_W+1)'(DEPTH) - w_count;
    assign Count      = w_count;
    assign Empty      = (w_count == '0);
    assign Disp_Ready = (w_free >= (IDX_W+1)'(DISP_LANES));
    assign w_disp     = Disp_Ready && (|Disp_V) && !Flush && !w_mis;
    assign w_disp_inc = Disp_V + DISP_LANES'(1);

    for (genvar k = 0; k < RET_LANES; k++) begin : g_ret
        assign w_ridx[k] = r_head[IDX_W-1:0] + IDX_W'(k);
        assign w_gpay[k] = r_pay[w_ridx[k]] & {ENT_W{w_ret[k]}};
    end
    for (genvar i = 0; i < DISP_LANES; i++) begin : g_disp
        assign w_didx[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
        assign Disp_Idx[i*IDX_W +: IDX_W] = w_didx[i];
    end
    // a completion is live only if its index lies in [head, tail)
    for (genvar p = 0; p < CPL_PORTS; p++) begin : g_cpl
        assign w_cidx[p] = Cpl_Idx[p*IDX_W +: IDX_W];
        assign w_cocc[p] = Cpl_V[p] && ({1'b0, w_cidx[p] - r_head[IDX_W-1:0]} < w_count);
    end

    always_comb begin
        logic w_go;
        w_ret  = '0;
        w_nret = '0;
        w_mis  = 1'b0;
        w_rpc  = '0;
        w_go   = !Flush;
        for (int unsigned k = 0; k < RET_LANES; k++) begin
            if (w_go && ((IDX_W+1)'(k) < w_count) && r_done[w_ridx[k]]) begin
                w_ret[k] = 1'b1;
                w_nret   = w_nret + (IDX_W+1)'(1);
                if (r_mis[w_ridx[k]]) begin
                    w_mis = 1'b1;
                    w_rpc = r_tgt[w_ridx[k]];
                    w_go  = 1'b0;
                end
            end else begin
                w_go = 1'b0;
            end
        end
    end

    always_comb begin
        w_ndisp = '0;
        for (int unsigned i = 0; i < DISP_LANES; i++)
            w_ndisp = w_ndisp + (IDX_W+1)'(Disp_V[i]);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_done      <= '0;
            r_mis       <= '0;
            Ret_V       <= '0;
            Ret_ARF     <= '0;
            Ret_RRF     <= '0;
            Ret_C_V     <= '0;
            Ret_Z_V     <= '0;
            Ret_C_Addr  <= '0;
            Ret_Z_Addr  <= '0;
            Ret_SB_V    <= '0;
            Ret_SB_Addr <= '0;
            Ret_PC      <= '0;
            Redirect_V  <= 1'b0;
            Redirect_PC <= '0;
        end else begin
            Redirect_V <= w_mis;
            if (w_mis)
                Redirect_PC <= w_rpc;
            r_head <= r_head + w_nret;
            if (Flush)
                r_tail <= r_head;
            else if (w_mis)
                r_tail <= r_head + w_nret;
            else if (w_disp)
                r_tail <= r_tail + w_ndisp;
            // later ports overwrite earlier ones on a shared index
            if (!Flush) begin
                for (int unsigned p = 0; p < CPL_PORTS; p++) begin
                    if (w_cocc[p]) begin
                        r_done[w_cidx[p]] <= 1'b1;
                        r_mis[w_cidx[p]]  <= Cpl_Mispred[p];
                    end
                end
            end
            if (w_disp) begin
                for (int unsigned i = 0; i < DISP_LANES; i++) begin
                    if (Disp_V[i]) begin
                        r_done[w_didx[i]] <= 1'b0;
                        r_mis[w_didx[i]]  <= 1'b0;
                    end
                end
            end
            for (int unsigned k = 0; k < RET_LANES; k++) begin
                Ret_V[k]                          <= w_ret[k];
                Ret_ARF[k*3 +: 3]                 <= w_gpay[k][OFF_ARF +: 3];
                Ret_RRF[k*RRF_SIZE +: RRF_SIZE]   <= w_gpay[k][OFF_RRF +: RRF_SIZE];
                Ret_PC[k*16 +: 16]                <= w_gpay[k][OFF_PC +: 16];
                Ret_C_V[k]                        <= w_gpay[k][OFF_CV];
                Ret_C_Addr[k*R_CZ_SIZE +: R_CZ_SIZE] <= w_gpay[k][OFF_CA +: R_CZ_SIZE];
                Ret_Z_V[k]                        <= w_gpay[k][OFF_ZV];
                Ret_Z_Addr[k*R_CZ_SIZE +: R_CZ_SIZE] <= w_gpay[k][OFF_ZA +: R_CZ_SIZE];
                Ret_SB_V[k]                       <= w_gpay[k][OFF_SBV];
                Ret_SB_Addr[k*SB_SIZE +: SB_SIZE] <= w_gpay[k][0 +: SB_SIZE];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && !Flush) begin
            for (int unsigned p = 0; p < CPL_PORTS; p++)
                if (w_cocc[p])
                    r_tgt[w_cidx[p]] <= Cpl_PC[p*16 +: 16];
        end
        if (RST_N && w_disp) begin
            for (int unsigned i = 0; i < DISP_LANES; i++)
                if (Disp_V[i])
                    r_pay[w_didx[i]] <= Disp_Data[i*ENT_W +: ENT_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N)
            assert ((Disp_V & w_disp_inc) == '0);
    end

`ifdef ROB_PERF_CNT_EN
    logic [32:0] w_perf_sum;
    assign w_perf_sum = {1'b0, Perf_Retired} + 33'(w_nret);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Perf_Retired   <= '0;
            Perf_Redirects <= '0;
        end else begin
            Perf_Retired <= w_perf_sum[32] ? '1 : w_perf_sum[31:0];
            if (Redirect_V && (Perf_Redirects != '1))
                Perf_Redirects <= Perf_Redirects + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rob_multi_issue.sv
// Scoreboard bench for rob_multi_issue: expected retires/redirects are queued at stimulus time
// and a negedge monitor pops and compares them against Ret_* / Redirect_*.
module tb_rob_multi_issue;
    localparam int ENT_W = 50;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         Flush;
    logic [1:0]   Disp_V;
    logic [99:0]  Disp_Data;
    logic         Disp_Ready;
    logic [13:0]  Disp_Idx;
    logic [2:0]   Cpl_V;
    logic [20:0]  Cpl_Idx;
    logic [2:0]   Cpl_Mispred;
    logic [47:0]  Cpl_PC;
    logic [1:0]   Ret_V, Ret_C_V, Ret_Z_V, Ret_SB_V;
    logic [5:0]   Ret_ARF;
    logic [13:0]  Ret_RRF;
    logic [15:0]  Ret_C_Addr, Ret_Z_Addr;
    logic [9:0]   Ret_SB_Addr;
    logic [31:0]  Ret_PC;
    logic         Redirect_V;
    logic [15:0]  Redirect_PC;
    logic [7:0]   Count;
    logic         Empty;

    rob_multi_issue #(.DEPTH(128), .IDX_W(7), .DISP_LANES(2), .RET_LANES(2), .CPL_PORTS(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .Flush(Flush),
        .Disp_V(Disp_V), .Disp_Data(Disp_Data), .Disp_Ready(Disp_Ready), .Disp_Idx(Disp_Idx),
        .Cpl_V(Cpl_V), .Cpl_Idx(Cpl_Idx), .Cpl_Mispred(Cpl_Mispred), .Cpl_PC(Cpl_PC),
        .Ret_V(Ret_V), .Ret_ARF(Ret_ARF), .Ret_RRF(Ret_RRF),
        .Ret_C_V(Ret_C_V), .Ret_Z_V(Ret_Z_V), .Ret_C_Addr(Ret_C_Addr), .Ret_Z_Addr(Ret_Z_Addr),
        .Ret_SB_V(Ret_SB_V), .Ret_SB_Addr(Ret_SB_Addr), .Ret_PC(Ret_PC),
        .Redirect_V(Redirect_V), .Redirect_PC(Redirect_PC), .Count(Count), .Empty(Empty)
    );

    always #5 CLK = ~CLK;

    typedef struct { int lane; logic [ENT_W-1:0] pay; } ret_t;
    ret_t             rq[$];
    logic [15:0]      redq[$];
    logic [ENT_W-1:0] exp_pay [128];
    int               n_chk = 0;
    int               n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // payload: ARF, RRF, PC, C_V, C_Addr, Z_V, Z_Addr, SB_V, SB_Addr
    function automatic logic [ENT_W-1:0] mk(input logic [15:0] pc);
        return {pc[2:0], pc[7:1], pc, pc[1], pc[7:0], pc[2], ~pc[7:0], pc[3], pc[5:1]};
    endfunction

    ret_t             m_e;
    logic [ENT_W-1:0] m_act;
    logic [15:0]      m_pc;
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (Ret_V[k]) begin
                m_act = {Ret_ARF[k*3 +: 3], Ret_RRF[k*7 +: 7], Ret_PC[k*16 +: 16], Ret_C_V[k],
                         Ret_C_Addr[k*8 +: 8], Ret_Z_V[k], Ret_Z_Addr[k*8 +: 8], Ret_SB_V[k],
                         Ret_SB_Addr[k*5 +: 5]};
                if (rq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_retire lane=%0d actual=%0h expected=none", k, m_act);
                end else begin
                    m_e = rq.pop_front();
                    chk("ret_payload", 64'(m_act), 64'(m_e.pay));
                    if (m_e.lane >= 0) chk("ret_lane", 64'(k), 64'(m_e.lane));
                end
            end
        end
        if (Redirect_V) begin
            if (redq.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_redirect actual=%0h expected=none", Redirect_PC);
            end else begin
                m_pc = redq.pop_front();
                chk("redirect_pc", 64'(Redirect_PC), 64'(m_pc));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        Flush = 0; Disp_V = '0; Disp_Data = '0;
        Cpl_V = '0; Cpl_Idx = '0; Cpl_Mispred = '0; Cpl_PC = '0;
    endtask

    task automatic do_reset();
        clr();
        RST_N = 0;
        idle(2);
        RST_N = 1;
    endtask

    task automatic disp(input int n, input int idx0, input logic [15:0] pc0);
        chk("disp_ready", 64'(Disp_Ready), 64'd1);
        for (int i = 0; i < n; i++) begin
            Disp_V[i] = 1'b1;
            Disp_Data[i*ENT_W +: ENT_W] = mk(pc0 + 16'(2*i));
            exp_pay[(idx0 + i) % 128] = mk(pc0 + 16'(2*i));
            chk("disp_idx", 64'(Disp_Idx[i*7 +: 7]), 64'((idx0 + i) % 128));
        end
        tick();
        Disp_V = '0; Disp_Data = '0;
    endtask

    task automatic raw_disp();
        Disp_V = 2'b11;
        Disp_Data = {mk(16'hDEAD), mk(16'hBEEF)};
    endtask

    task automatic set_cpl(input int p, input int idx, input logic mis, input logic [15:0] pc);
        logic [6:0] i7;
        i7 = 7'(idx);
        Cpl_V[p] = 1'b1;
        Cpl_Idx[p*7 +: 7] = i7;
        Cpl_Mispred[p] = mis;
        Cpl_PC[p*16 +: 16] = pc;
    endtask

    task automatic push_ret(input int lane, input int idx);
        ret_t e;
        e.lane = lane;
        e.pay  = exp_pay[idx];
        rq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 0;
        clr();
        // basic dispatch, out-of-order completion, dual retire
        do_reset();
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_ret_v", 64'(Ret_V), 64'd0);
        chk("rst_redir_v", 64'(Redirect_V), 64'd0);
        chk("rst_redir_pc", 64'(Redirect_PC), 64'd0);
        disp(2, 0, 16'h0010);
        chk("t1_count", 64'(Count), 64'd2);
        chk("t1_empty", 64'(Empty), 64'd0);
        set_cpl(0, 1, 0, 0); tick(); clr();
        push_ret(0, 0); push_ret(1, 1);
        set_cpl(1, 0, 0, 0); tick(); clr();
        idle(3);
        chk("t1_count_end", 64'(Count), 64'd0);
        chk("t1_drain", 64'(rq.size()), 64'd0);

        // fill, full boundary, wrap
        do_reset();
        for (int c = 0; c < 63; c++) disp(2, 2*c, 16'h0100 + 16'(4*c));
        chk("t2_count126", 64'(Count), 64'd126);
        disp(1, 126, 16'h0300);
        chk("t2_count127", 64'(Count), 64'd127);
        chk("t2_ready0", 64'(Disp_Ready), 64'd0);
        raw_disp(); tick(); clr();
        chk("t2_drop", 64'(Count), 64'd127);
        set_cpl(0, 0, 0, 0); set_cpl(1, 1, 0, 0);
        push_ret(0, 0); push_ret(1, 1);
        tick(); clr();
        idle(3);
        chk("t2_count125", 64'(Count), 64'd125);
        chk("t2_ready1", 64'(Disp_Ready), 64'd1);
        disp(2, 127, 16'h0400);
        chk("t2_count_wrap", 64'(Count), 64'd127);
        for (int j = 0; j < 127; j += 2) begin
            for (int q = 0; q < 2; q++) begin
                if (j + q < 127) begin
                    set_cpl(q, (2 + j + q) % 128, 0, 0);
                    push_ret(-1, (2 + j + q) % 128);
                end
            end
            tick(); clr();
        end
        idle(5);
        chk("t2_count_end", 64'(Count), 64'd0);
        chk("t2_drain", 64'(rq.size()), 64'd0);

        // retire stops at first not-done entry
        do_reset();
        disp(2, 0, 16'h0020);
        disp(1, 2, 16'h0024);
        set_cpl(0, 0, 0, 0); set_cpl(1, 2, 0, 0);
        push_ret(0, 0);
        tick(); clr();
        idle(4);
        chk("t3_count_wait", 64'(Count), 64'd2);
        set_cpl(2, 1, 0, 0);
        push_ret(0, 1); push_ret(1, 2);
        tick(); clr();
        idle(3);
        chk("t3_count_end", 64'(Count), 64'd0);
        chk("t3_drain", 64'(rq.size()), 64'd0);

        // mispredict with younger entries and a same-cycle dispatch
        do_reset();
        disp(2, 0, 16'h0030); disp(2, 2, 16'h0034); disp(2, 4, 16'h0038);
        chk("t4_count6", 64'(Count), 64'd6);
        set_cpl(0, 0, 1, 16'h0040); set_cpl(1, 1, 0, 0);
        push_ret(0, 0); redq.push_back(16'h0040);
        tick(); clr();
        raw_disp(); tick(); clr();
        chk("t4_count0", 64'(Count), 64'd0);
        chk("t4_redir_v1", 64'(Redirect_V), 64'd1);
        tick();
        chk("t4_redir_v0", 64'(Redirect_V), 64'd0);
        idle(3);
        chk("t4_count_end", 64'(Count), 64'd0);
        chk("t4_next_idx", 64'(Disp_Idx[6:0]), 64'd1);
        chk("t4_drain", 64'(rq.size() + redq.size()), 64'd0);

        // flush beats concurrent dispatch and completion
        do_reset();
        disp(2, 0, 16'h0060); disp(2, 2, 16'h0064);
        set_cpl(0, 0, 0, 0); push_ret(0, 0);
        tick(); clr();
        idle(3);
        chk("t5_count3", 64'(Count), 64'd3);
        Flush = 1; raw_disp(); set_cpl(1, 1, 0, 0);
        tick(); clr();
        chk("t5_count0", 64'(Count), 64'd0);
        chk("t5_empty", 64'(Empty), 64'd1);
        chk("t5_ret_v", 64'(Ret_V), 64'd0);
        chk("t5_idx_old_head", 64'(Disp_Idx[6:0]), 64'd1);
        disp(1, 1, 16'h0068);
        idle(3);
        chk("t5_not_done", 64'(Count), 64'd1);
        chk("t5_drain", 64'(rq.size()), 64'd0);

        // same index on two ports, then reset during redirect
        do_reset();
        disp(2, 0, 16'h0070);
        set_cpl(0, 0, 1, 16'h0111); set_cpl(2, 0, 1, 16'h0222);
        push_ret(0, 0); redq.push_back(16'h0222);
        tick(); clr();
        tick();
        chk("t6_redir_v", 64'(Redirect_V), 64'd1);
        RST_N = 0; raw_disp();
        tick(); clr(); RST_N = 1;
        chk("t6_rst_ret_v", 64'(Ret_V), 64'd0);
        chk("t6_rst_ret_pc", 64'(Ret_PC), 64'd0);
        chk("t6_rst_redir_v", 64'(Redirect_V), 64'd0);
        chk("t6_rst_redir_pc", 64'(Redirect_PC), 64'd0);
        chk("t6_rst_count", 64'(Count), 64'd0);
        idle(2);
        chk("t6_drain", 64'(rq.size() + redq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
